// File: rtl/darkbus_pkg.sv
// Shared types for device_bus targets: request encoding, responder FSM states, bus widths.
package darkbus_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } rsp_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bus_op_t;

  typedef struct packed {
    bus_op_t             op;
    logic [ADDR_W-1:0]   addr;
  } bus_req_t;
endpackage

// File: rtl/dark_sram_1rw.sv
// Synchronous single-port word RAM; read data registered one cycle after en, held between reads.
module dark_sram_1rw
  import darkbus_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/darkram_resp.sv
// device_bus RAM target: IDLE->WAIT->ACK responder with per-op wait states and tri-state read return.
module darkram_resp
  import darkbus_pkg::*;
#(
  parameter int    DEPTH      = 1024,
  parameter int    READ_WAIT  = 0,
  parameter int    WRITE_WAIT = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic              XCLK,
  input  logic              XRES,
  input  logic              BUS_EN,
  input  logic              BUS_RE,
  input  logic              BUS_WE,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  inout  wire  [DATA_W-1:0] BUS_DATA,
  output logic              BUS_RACK,
  output logic              BUS_WACK
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] RWAIT = 4'(READ_WAIT);
  localparam logic [3:0] WWAIT = 4'(WRITE_WAIT);

  rsp_state_t        state_q, state_d;
  bus_req_t          req_q, req_d, cur;
  logic [3:0]        cnt_q, cnt_d, wsel;
  logic              rack_q, rack_d, wack_q, wack_d;
  logic              rsel_q, rsel_d;
  logic              req_vld, same, start, commit, in_range;
  logic [DATA_W-1:0] ram_rdata, rdata;

  always_comb begin
    req_vld  = BUS_EN && (BUS_RE || BUS_WE);
    cur.op   = BUS_RE ? OP_RD : OP_WR;
    cur.addr = BUS_ADDR;
    same     = req_vld && (cur == req_q);
    wsel     = (cur.op == OP_RD) ? RWAIT : WWAIT;
    in_range = (BUS_ADDR >> (AW + 2)) == '0;
  end

  // Any mismatch outside a held request is handled exactly like a fresh request
  // seen in IDLE, which gives back-to-back acks and clean aborts for free.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!same)               start  = 1'b1;
        else if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end else                 cnt_d  = cnt_q - 4'd1;
      end
      ST_ACK:  if (!same) start = 1'b1;
      default: start = 1'b1;
    endcase
    if (start) begin
      state_d = ST_IDLE;
      if (req_vld) begin
        req_d = cur;
        if (wsel == 4'd0) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = wsel - 4'd1;
        end
      end
    end
  end

  // A commit always happens while the bus still presents the committed request,
  // so the live ADDR/DATA are the ones to use.  Out-of-range reads return zero.
  always_comb begin
    rsel_d = rsel_q;
    if (commit && cur.op == OP_RD) rsel_d = in_range;
    rack_d = (state_d == ST_ACK) && (req_d.op == OP_RD);
    wack_d = (state_d == ST_ACK) && (req_d.op == OP_WR);
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      rsel_q  <= rsel_d;
    end
  end

  dark_sram_1rw #(.DEPTH(DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (XCLK),
    .en    (commit && in_range),
    .we    (cur.op == OP_WR),
    .addr  (BUS_ADDR[AW+1:2]),
    .wdata (BUS_DATA),
    .rdata (ram_rdata)
  );

  assign rdata    = rsel_q ? ram_rdata : '0;
  assign BUS_DATA = (XRES && BUS_EN && BUS_RE) ? rdata : 'z;
  assign BUS_RACK = rack_q;
  assign BUS_WACK = wack_q;
endmodule

// File: tb/tb_darkram_resp.sv
// Two responders (no waits / 3-read 2-write waits) share one stimulus stream against a request-age model.
module tb_darkram_resp;
  localparam int DEPTH = 16;
  localparam int RW1   = 3;
  localparam int WW1   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0, xres = 1'b0, en = 1'b0, re = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  wire  [31:0] data0, data1;
  logic        rack0, wack0, rack1, wack1;
  wire         tb_oe = !(en && re);
  int          vecs = 0, errs = 0;

  assign data0 = tb_oe ? wdata : 'z;
  assign data1 = tb_oe ? wdata : 'z;

  always #5 clk = ~clk;

  darkram_resp #(.DEPTH(DEPTH), .READ_WAIT(0), .WRITE_WAIT(0)) u0 (
    .XCLK(clk), .XRES(xres), .BUS_EN(en), .BUS_RE(re), .BUS_WE(we),
    .BUS_ADDR(addr), .BUS_DATA(data0), .BUS_RACK(rack0), .BUS_WACK(wack0));

  darkram_resp #(.DEPTH(DEPTH), .READ_WAIT(RW1), .WRITE_WAIT(WW1)) u1 (
    .XCLK(clk), .XRES(xres), .BUS_EN(en), .BUS_RE(re), .BUS_WE(we),
    .BUS_ADDR(addr), .BUS_DATA(data1), .BUS_RACK(rack1), .BUS_WACK(wack1));

  // Model: a request is acked once it has been sampled unchanged on 1+wait
  // consecutive edges; the access takes effect on the edge that reaches it.
  logic [31:0] m_mem [2][DEPTH];
  logic [31:0] m_rd    [2] = '{32'h0, 32'h0};
  int          age     [2] = '{0, 0};
  logic        p_rd    [2] = '{1'b0, 1'b0};
  logic [31:0] p_addr  [2] = '{32'h0, 32'h0};
  logic        m_rack  [2] = '{1'b0, 1'b0};
  logic        m_wack  [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge xres) begin
    logic rd, wr, inr;
    int   w;
    if (!xres) begin
      for (int i = 0; i < 2; i++) begin
        age[i] = 0; m_rd[i] = '0; m_rack[i] = 1'b0; m_wack[i] = 1'b0;
      end
    end else begin
      rd  = en && re;
      wr  = en && we && !re;
      inr = addr < 32'(DEPTH * 4);
      for (int i = 0; i < 2; i++) begin
        w = (i == 0) ? 0 : (rd ? RW1 : WW1);
        if (!(rd || wr)) age[i] = 0;
        else if (age[i] > 0 && p_rd[i] == rd && p_addr[i] == addr) begin
          if (age[i] < 1000) age[i]++;
        end else begin
          age[i] = 1; p_rd[i] = rd; p_addr[i] = addr;
        end
        if ((rd || wr) && age[i] == w + 1) begin
          if (rd)       m_rd[i] = inr ? m_mem[i][addr[AW+1:2]] : 32'h0;
          else if (inr) m_mem[i][addr[AW+1:2]] = wdata;
        end
        m_rack[i] = rd && (age[i] > w);
        m_wack[i] = wr && (age[i] > w);
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk1("rack0", rack0, m_rack[0]);
    chk1("wack0", wack0, m_wack[0]);
    chk1("rack1", rack1, m_rack[1]);
    chk1("wack1", wack1, m_wack[1]);
    if (xres && en && re) begin
      chk32("data0", data0, m_rd[0]);
      chk32("data1", data1, m_rd[1]);
    end
  end

  function automatic logic [31:0] f(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic cyc(input logic e, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    en = e; re = r; we = w; addr = a; wdata = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #4;
    chk1("rst_rack0", rack0, 1'b0); chk1("rst_wack1", wack1, 1'b0);
    #1 xres = 1'b1;

    for (int i = 0; i < DEPTH; i++) repeat (3) cyc(1, 0, 1, 32'(i * 4), f(i));
    cyc(0, 0, 0, 0, 0);

    // Write then read 0x10.
    cyc(1, 0, 1, 32'h10, 32'hDEADBEEF); cyc(1, 0, 1, 32'h10, 32'hDEADBEEF);
    #2 chk1("t1_wack0", wack0, 1'b1); chk1("t1_wack1_early", wack1, 1'b0);
    cyc(1, 0, 1, 32'h10, 32'hDEADBEEF);
    #2 chk1("t1_wack1_wait", wack1, 1'b0);
    cyc(1, 0, 1, 32'h10, 32'hDEADBEEF);
    #2 chk1("t1_wack1", wack1, 1'b1);
    cyc(1, 1, 0, 32'h10, 0); cyc(1, 1, 0, 32'h10, 0);
    #2 chk1("t1_rack0", rack0, 1'b1); chk32("t1_data0", data0, 32'hDEADBEEF);
    chk1("t2_rack1_early", rack1, 1'b0);
    cyc(1, 1, 0, 32'h10, 0); cyc(1, 1, 0, 32'h10, 0);
    #2 chk1("t2_rack1_wait", rack1, 1'b0);
    cyc(1, 1, 0, 32'h10, 0);
    #2 chk1("t2_rack1", rack1, 1'b1); chk32("t2_data1", data1, 32'hDEADBEEF);

    // Back-to-back reads with ADDR stepping.
    cyc(1, 1, 0, 32'h0, 0); cyc(1, 1, 0, 32'h4, 0);
    #2 chk1("t3_rack_a", rack0, 1'b1); chk32("t3_w0", data0, f(0));
    cyc(1, 1, 0, 32'h8, 0);
    #2 chk1("t3_rack_b", rack0, 1'b1); chk32("t3_w1", data0, f(1));
    cyc(1, 1, 0, 32'h8, 0);
    #2 chk1("t3_rack_c", rack0, 1'b1); chk32("t3_w2", data0, f(2));

    // Write aborted during wait on u1 only.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h20, 32'h12345678); cyc(1, 0, 1, 32'h20, 32'h12345678);
    #2 chk1("t4_wack1_a", wack1, 1'b0);
    cyc(0, 0, 0, 0, 0);
    #2 chk1("t4_wack1_b", wack1, 1'b0);
    repeat (5) cyc(1, 1, 0, 32'h20, 0);
    #2 chk1("t4_rack1", rack1, 1'b1); chk32("t4_old", data1, f(8));
    chk32("t4_new0", data0, 32'h12345678);

    // Out-of-range write and read.
    repeat (2) cyc(1, 0, 1, 32'(DEPTH * 4), 32'h5A5A5A5A);
    #2 chk1("t5_wack0", wack0, 1'b1);
    repeat (2) cyc(1, 0, 1, 32'(DEPTH * 4), 32'h5A5A5A5A);
    #2 chk1("t5_wack1", wack1, 1'b1);
    repeat (5) cyc(1, 1, 0, 32'h0, 0);
    #2 chk32("t5_w0_u0", data0, f(0)); chk32("t5_w0_u1", data1, f(0));
    repeat (2) cyc(1, 1, 0, 32'(DEPTH * 4), 0);
    #2 chk1("t5_rack0", rack0, 1'b1); chk32("t5_oor0", data0, 32'h0);
    repeat (3) cyc(1, 1, 0, 32'(DEPTH * 4), 0);
    #2 chk1("t5_rack1", rack1, 1'b1); chk32("t5_oor1", data1, 32'h0);

    // Reset in the middle of u1's write wait.
    repeat (2) cyc(1, 0, 1, 32'h24, 32'hCAFEF00D);
    #1 xres = 1'b0;
    #1 chk1("t6_wack0", wack0, 1'b0); chk1("t6_wack1", wack1, 1'b0);
    chk1("t6_rack0", rack0, 1'b0);
    en = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #3 xres = 1'b1;
    repeat (5) cyc(1, 1, 0, 32'h24, 0);
    #2 chk1("t6_rack1", rack1, 1'b1); chk32("t6_old1", data1, f(9));
    chk32("t6_new0", data0, 32'hCAFEF00D);

    // RE and WE together: read only.
    repeat (2) cyc(1, 1, 1, 32'h28, 32'h0BADF00D);
    #2 chk1("t7_rack0", rack0, 1'b1); chk1("t7_wack0", wack0, 1'b0);
    chk32("t7_data0", data0, f(10));
    cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 32'h28, 0);
    #2 chk32("t7_keep0", data0, f(10));

    // Random traffic, requests held for a random number of cycles.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 99) < 30) begin
        en    = $urandom_range(0, 99) < 85;
        re    = 1'($urandom_range(0, 1));
        we    = 1'($urandom_range(0, 1));
        addr  = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) addr = $urandom;
        wdata = $urandom;
      end
    end
    cyc(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
